// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8-bit asynchronous serial receiver (LSB first, one stop bit).
//
// The rx line is brought into the clk domain through a SYNC_STAGES-deep flop
// chain. Each bit is then sampled at its midpoint, timed by a per-bit counter.
//
// Optional feature: define the macro UART_RX_PARITY_EN to add a parity bit
// between the data bits and the stop bit. PARITY_ODD = 0 selects even parity
// and 1 selects odd parity. Without the macro the frame is 10 bits long and
// rx_parity_err is held at 0. The port list is the same in both builds.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//   SYNC_STAGES   rx synchronizer depth (2..4)
//   PARITY_ODD    0 = even, 1 = odd (used only with UART_RX_PARITY_EN)
//
// Ports:
//   clk            rising-edge clock for all state
//   rst_n          synchronous active-low reset
//   rx             asynchronous serial input, idle high
//   rx_data        last correctly framed byte (holds until the next good frame)
//   rx_valid       1-cycle pulse: rx_data was updated this cycle
//   rx_frame_err   1-cycle pulse: stop bit sampled low
//   rx_parity_err  1-cycle pulse together with rx_valid: parity mismatch
//   rx_busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // Reject illegal parameter values at elaboration time.
    generate
        if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 ||
            SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_rx: parameter out of legal range");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Input synchronizer. It resets to all ones, which is the idle level.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync[gi] <= 1'b1;
                end else begin
                    if (gi == 0) begin
                        r_sync[gi] <= rx;
                    end else begin
                        r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    // r_armed is set once rx_s has been seen high since reset. A line that
    // is still low when reset is released therefore cannot start a frame.
    logic            r_armed;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit;
`endif
    logic            w_bit_point;

    assign w_bit_point = (r_cnt == BIT_LAST);
    assign rx_busy     = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_armed       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit     <= 1'b0;
`endif
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            r_cnt         <= r_cnt + 1'b1;
            if (w_rx_s) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (r_armed && !w_rx_s) begin
                        r_state <= S_START;
                    end
                end

                // Re-check the start bit at its midpoint. This filters out
                // short glitches and sets the sampling phase for the
                // rest of the frame.
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_bit_point) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_point) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_point) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            rx_parity_err <= (^r_shift) ^ r_par_bit ^ PARITY_ODD[0];
`endif
                            r_state  <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            r_state      <= S_BREAK;
                        end
                    end
                end

                // Stay here while the line is held low after a framing
                // error, so that a long break gives only one error pulse.
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int N   = 16;
    localparam int S   = 2;
    localparam int H   = N / 2;
    localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    // Cycles from the first clock edge that sees rx low at the pin to the
    // stop-sample edge: synchronizer depth, half a bit, then 8 data bits,
    // the optional parity bit and the stop bit.
    localparam int LAT = S + H + (9 + PB) * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    uart_rx #(
        .CLKS_PER_BIT (N),
        .SYNC_STAGES  (S),
        .PARITY_ODD   (ODD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         perr;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_ferr = 0;
    int         prev_valid_cyc = 0;
    int         last_valid_cyc = 0;
    logic [7:0] mdl_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Output monitor: each pulse is matched in order against the expected events.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_data = 8'h00;
        end else begin
            if (rx_valid && rx_frame_err) check("valid_and_ferr", 1, 0);
            if (rx_parity_err && !rx_valid) check("perr_without_valid", 1, 0);
            if (rx_frame_err) n_ferr++;
            if (rx_valid || rx_frame_err) begin
                if (exp_q.size() == 0) begin
                    check(rx_valid ? "unexpected_valid" : "unexpected_ferr", 1, 0);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("kind", {31'd0, rx_frame_err}, {31'd0, ev.is_err});
                    check("cycle", cyc, ev.at);
                    if (!ev.is_err) begin
                        check("data", {24'd0, rx_data}, {24'd0, ev.data});
                        check("parity_err", {31'd0, rx_parity_err}, {31'd0, ev.perr});
                        mdl_data = ev.data;
                        prev_valid_cyc = last_valid_cyc;
                        last_valid_cyc = cyc;
                        $display("rx byte 0x%02h perr=%0d at cycle %0d", rx_data, rx_parity_err, cyc);
                    end else begin
                        check("data_hold", {24'd0, rx_data}, {24'd0, mdl_data});
                        $display("frame error at cycle %0d, rx_data held 0x%02h", cyc, rx_data);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, starting and ending on a negedge. If expect_it is set,
    // the pulse the frame should produce is queued first.
    task automatic send_frame(input logic [7:0] data, input bit stop, input bit pbit,
                              input int extra_low, input bit expect_it);
        ev_t ev;
        ev.is_err = !stop;
        ev.data   = data;
        ev.perr   = (PB == 1) ? ((^data) ^ pbit ^ ODD[0]) : 1'b0;
        ev.at     = cyc + 1 + LAT;
        if (expect_it) exp_q.push_back(ev);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (N) @(negedge clk);
        end
        if (PB == 1) begin
            rx = pbit;
            repeat (N) @(negedge clk);
        end
        rx = stop;
        repeat (N) @(negedge clk);
        if (!stop) repeat (extra_low) @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int e;
        int f0;
        bit was_busy;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_ferr", {31'd0, rx_frame_err}, 0);
        check("rst_perr", {31'd0, rx_parity_err}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        rst_n = 1'b1;
        idle(2 * N);

        // A single good frame.
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b1);
        idle(N);

        // Two frames back to back, with no idle time between them.
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1, 0, 1'b1);
        idle(N);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, (10 + PB) * N);

        // A 5-cycle glitch: busy for exactly H cycles, back to idle at T0+H.
        e = cyc + 1;
        rx = 1'b0;
        busy_cnt = 0;
        was_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) rx = 1'b1;
            @(negedge clk);
            if (rx_busy) busy_cnt++;
            if (was_busy && !rx_busy) check("glitch_idle_cycle", cyc, e + S + H);
            was_busy = rx_busy;
        end
        check("glitch_busy_cycles", busy_cnt, H);

        // Framing error with the line held low for a long time.
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b1);
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, 400, 1'b1);
        idle(2 * N);
        check("break_single_ferr", n_ferr - f0, 1);
        check("break_data_held", {24'd0, rx_data}, 32'h5A);
        send_frame(8'h12, 1'b1, 1'b0, 0, 1'b1);
        idle(N);

        // Reset in the middle of a frame.
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b0);
            begin
                repeat (S + 70) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_data", {24'd0, rx_data}, 32'h00);
                check("midrst_valid", {31'd0, rx_valid}, 0);
                check("midrst_ferr", {31'd0, rx_frame_err}, 0);
                check("midrst_perr", {31'd0, rx_parity_err}, 0);
                check("midrst_busy", {31'd0, rx_busy}, 0);
                rst_n = 1'b1;
            end
        join
        idle(N);
        send_frame(8'h81, 1'b1, 1'b0, 0, 1'b1);
        idle(N);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, so even parity expects a parity bit of 1.
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b1);
        idle(N);
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b1);
        idle(N);
`endif

        // Random mix: frames, back-to-back runs, glitches and framing errors.
        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, H - 2)) @(negedge clk);
                idle(N);
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, 1'($urandom), $urandom_range(0, 60), 1'b1);
                idle(2 * N);
            end else begin
                send_frame(8'($urandom), 1'b1, 1'($urandom), 0, 1'b1);
                idle($urandom_range(0, 3));
            end
        end

        idle(3 * N);
        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; the legal range SHALL be 4..65535.
REQ-003 Parameter SYNC_STAGES, default 2: flops in the rx input synchronizer; the legal range SHALL be 2..4.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; it SHALL be used only with UART_RX_PARITY_EN.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 rx  in  1  asynchronous serial line, idle high.
REQ-008 rx_data  out  8  last correctly framed byte; holds until the next good frame.
REQ-009 rx_valid  out  1  one-cycle pulse: rx_data was updated this cycle.
REQ-010 rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-011 rx_parity_err  out  1  one-cycle pulse, coincident with rx_valid: parity mismatch.
REQ-012 rx_busy  out  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through SYNC_STAGES flops (reset value 1); rx_s is the last stage and is the only rx value the FSM observes.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BREAK; PARITY exists only when the macro is defined.
REQ-015 In IDLE, the edge that sees rx_s==0 (T0) SHALL move to START and clear the bit counter.
REQ-016 Let H = floor(CLKS_PER_BIT/2) and N = CLKS_PER_BIT; START SHALL re-sample rx_s at T0+H.
REQ-017 At T0+H, if rx_s==1 (glitch), START SHALL return to IDLE with no output pulse; otherwise it SHALL enter DATA.
REQ-018 Data bit i (i=0..7, LSB first) SHALL be sampled at T0+H+(i+1)*N into a shift register.
REQ-019 With parity enabled, the parity bit SHALL be sampled at T0+H+9N and the stop bit at T0+H+10N; without parity, the stop bit SHALL be sampled at T0+H+9N.
REQ-020 If the stop sample is 1, then at that same edge rx_data SHALL load the shift register, rx_valid SHALL assert for exactly one cycle, and the FSM SHALL move to IDLE.
REQ-021 If the stop sample is 0, rx_frame_err SHALL pulse for one cycle, rx_data SHALL be left unchanged, rx_valid SHALL stay low, and the FSM SHALL enter BREAK.
REQ-022 BREAK SHALL remain until rx_s==1, then go to IDLE; a held-low line SHALL yield exactly one rx_frame_err.
REQ-023 The bit-timing counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, SHALL wrap to 0 at each sample point, and SHALL clear on every state entry.
REQ-024 A start bit that begins any time after the stop-sample edge SHALL be detected; there SHALL be no dead cycle between back-to-back frames.
REQ-025 There SHALL be no backpressure; the consumer SHALL capture rx_data on rx_valid, and a later frame overwrites it.
REQ-026 rx_valid, rx_frame_err and rx_parity_err SHALL be registered outputs, and no two of rx_valid and rx_frame_err SHALL assert in the same cycle.

Reset
REQ-027 When rst_n==0 at a clk edge, state SHALL become IDLE, the synchronizer SHALL become all-ones, and counters and the shift register SHALL become 0.
REQ-028 Reset values SHALL be: rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; after rst_n rises, only a fresh high-to-low transition on rx_s SHALL start a frame.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL be present, frames SHALL be 1 start + 8 data + 1 parity + 1 stop bits, and rx_parity_err SHALL equal the XOR of the 8 data bits, the parity bit and PARITY_ODD, asserted with rx_valid.
REQ-031 Without the macro, the frame SHALL be 10 bits, rx_parity_err SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-032 N=16, no parity, frame 8'hA5 with stop=1 -> one rx_valid pulse with rx_data=8'hA5 at T0+8+144, rx_frame_err=0 throughout.
REQ-033 N=16, 0x3C immediately followed by 0xC3 with no idle gap -> two rx_valid pulses exactly 160 cycles apart, with data 0x3C then 0xC3.
REQ-034 N=16, rx low for 5 cycles then high -> FSM returns to IDLE at T0+8 with no pulses, and rx_busy is high for 8 cycles.
REQ-035 N=16, frame 0x55 with stop=0 and rx held low for 400 cycles -> exactly one rx_frame_err pulse, rx_data keeps its old value, and the next good frame 0x12 is received.
REQ-036 rst_n pulled low at T0+70 of frame 0xFF -> all outputs at reset values, no rx_valid, and the following frame 0x81 is received correctly.
REQ-037 UART_RX_PARITY_EN with PARITY_ODD=0: frame 0x07 with parity=1 -> rx_valid with rx_parity_err=0; parity=0 -> rx_valid with rx_parity_err=1.
